// File: rtl/gpio_pkg.sv
// gpio_pkg: register map indices and default parameters shared by the GPIO block
package gpio_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  typedef enum logic [2:0] {
    IDX_DATA_OUT,
    IDX_DIR,
    IDX_DATA_IN,
    IDX_IRQ_EN,
    IDX_IRQ_EDGE,
    IDX_IRQ_STATUS,
    IDX_SET,
    IDX_CLR
  } reg_idx_e;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: multi-stage flip-flop synchronizer for asynchronous pin inputs
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;
  // shift pins through the chain; stage 0 takes the raw input
  always_ff @(posedge clk or negedge reset)
    if (!reset) stage <= '0;
    else stage <= {stage[SYNC_STAGES-2:0], d};
  assign q = stage[SYNC_STAGES-1];
endmodule

// File: rtl/gpio_mmio_ctrl.sv
// gpio_mmio_ctrl: memory-mapped GPIO with direction control, set/clear and edge interrupts
module gpio_mmio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             write_en,
  input  logic [4:0]       address,
  input  logic [31:0]      write_data,
  output logic [31:0]      read_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] data_out, dir, irq_en, irq_edge, irq_status, data_in, prev, evt, wd, clr_mask, rd;
  logic             wr;
  reg_idx_e         idx;
  logic             unused;
  assign unused = ^{address[1:0], write_data};
  assign wr = sel & write_en;
  assign idx = reg_idx_e'(address[4:2]);
  assign wd = write_data[WIDTH-1:0];
  assign clr_mask = (wr && idx == IDX_IRQ_STATUS) ? wd : '0;
  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(gpio_in),
    .q(data_in)
  );
  assign evt = (irq_edge & data_in & ~prev) | (~irq_edge & ~data_in & prev);
  // register writes, edge history and sticky status; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      data_out   <= OUT_RESET;
      dir        <= '0;
      irq_en     <= '0;
      irq_edge   <= '1;
      irq_status <= '0;
      prev       <= '0;
    end else begin
      prev       <= data_in;
      irq_status <= (irq_status & ~clr_mask) | evt;
      if (wr)
        case (idx)
          IDX_DATA_OUT: data_out <= wd;
          IDX_DIR:      dir      <= wd;
          IDX_IRQ_EN:   irq_en   <= wd;
          IDX_IRQ_EDGE: irq_edge <= wd;
          IDX_SET:      data_out <= data_out | wd;
          IDX_CLR:      data_out <= data_out & ~wd;
          default: ;
        endcase
    end
  // read mux; SET and CLR have no readable state
  always_comb begin
    rd = '0;
    case (idx)
      IDX_DATA_OUT:   rd = data_out;
      IDX_DIR:        rd = dir;
      IDX_DATA_IN:    rd = data_in;
      IDX_IRQ_EN:     rd = irq_en;
      IDX_IRQ_EDGE:   rd = irq_edge;
      IDX_IRQ_STATUS: rd = irq_status;
      default:        rd = '0;
    endcase
  end
  assign read_data = sel ? 32'(rd) : 32'h0;
  assign gpio_out = data_out;
  assign gpio_oe = dir;
  assign irq = |(irq_status & irq_en);
endmodule
